// File: rtl/soc_pkg.sv
// soc_pkg: shared boot-loader state encoding and widths
package soc_pkg;
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERROR} boot_state_t;
  localparam int WORD_W = 32;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer: assembles four bytes into a little-endian word with a completion strobe
module byte_to_word_packer
  import soc_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done
);
  logic [1:0]        r_cnt;
  logic [WORD_W-9:0] r_shift;
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_data, r_shift[WORD_W-9:8]};
    end
  end
  // the fourth byte is combined live so the word is ready on its own handshake edge
  assign o_word = {i_data, r_shift};
  assign o_done = i_valid && &r_cnt;
endmodule

// File: rtl/soc_boot_loader.sv
// soc_boot_loader: streams a length-prefixed image into instruction memory, holding the core in reset until done
// Optional trailing XOR checksum byte enabled by BOOT_CHECKSUM_EN.
module soc_boot_loader
  import soc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [7:0]            In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  Boot_Req,
  output logic                  Mem_WrEn,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [WORD_W-1:0]     Mem_WrData,
  output logic                  Core_Rst,
  output logic                  Done,
  output logic                  Error
);
  localparam logic [16:0] MAX_N = 17'((1 << ADDR_WIDTH) - BASE_ADDR);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_t S_END = S_CHK;
  logic [7:0] r_csum;
`else
  localparam boot_state_t S_END = S_DONE;
`endif
  boot_state_t           r_state, w_next;
  logic [15:0]           r_n, r_wcnt, w_n;
  logic                  r_core_rst, r_done, r_error, r_wren;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_W-1:0]     r_wdata, w_word;
  logic                  w_acc, w_word_done, w_reload;
  assign In_Ready = Rst && (r_state == S_HDR0 || r_state == S_HDR1 || r_state == S_DATA || r_state == S_CHK);
  assign w_acc    = In_Valid && In_Ready;
  assign w_n      = {In_Data, r_n[7:0]};
  assign w_reload = Boot_Req && (r_state == S_DONE || r_state == S_ERROR);
  byte_to_word_packer u_packer (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_valid (w_acc && r_state == S_DATA),
    .i_data  (In_Data),
    .o_word  (w_word),
    .o_done  (w_word_done)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0:  w_next = w_acc ? S_HDR1 : S_HDR0;
      S_HDR1:  w_next = !w_acc ? S_HDR1 : w_n == 16'd0 ? S_END : {1'b0, w_n} > MAX_N ? S_ERROR : S_DATA;
      S_DATA:  w_next = (w_word_done && r_wcnt + 16'd1 == r_n) ? S_END : S_DATA;
`ifdef BOOT_CHECKSUM_EN
      S_CHK:   w_next = !w_acc ? S_CHK : In_Data == r_csum ? S_DONE : S_ERROR;
`endif
      S_DONE,
      S_ERROR: w_next = w_reload ? S_HDR0 : r_state;
      default: w_next = S_ERROR;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= S_HDR0;
      r_n        <= '0;
      r_wcnt     <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wren     <= 1'b0;
      r_addr     <= ADDR_WIDTH'(BASE_ADDR);
      r_wdata    <= '0;
`ifdef BOOT_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_done     <= w_next == S_DONE;
      r_error    <= w_next == S_ERROR;
      r_core_rst <= w_next != S_DONE;
      r_wren     <= w_word_done;
      if (r_state == S_HDR0 && w_acc) r_n[7:0] <= In_Data;
      if (r_state == S_HDR1 && w_acc) r_n[15:8] <= In_Data;
      if (w_word_done) begin
        r_addr  <= ADDR_WIDTH'(BASE_ADDR + int'(r_wcnt));
        r_wdata <= w_word;
        r_wcnt  <= r_wcnt + 16'd1;
      end
      if (w_reload) r_wcnt <= '0;
`ifdef BOOT_CHECKSUM_EN
      if (w_reload) r_csum <= '0;
      else if (w_acc && r_state != S_CHK) r_csum <= r_csum ^ In_Data;
`endif
    end
  end
  assign Mem_WrEn   = r_wren;
  assign Mem_Addr   = r_addr;
  assign Mem_WrData = r_wdata;
  assign Core_Rst   = r_core_rst;
  assign Done       = r_done;
  assign Error      = r_error;
endmodule

// File: tb/tb_soc_boot_loader.sv
// tb_soc_boot_loader: scoreboard bench for soc_boot_loader; follows BOOT_CHECKSUM_EN like the RTL
module tb_soc_boot_loader;
  localparam int AW = 12;
  localparam int BASE = 0;
  logic          Clk = 1'b0, Rst = 1'b0, In_Valid = 1'b0, Boot_Req = 1'b0;
  logic [7:0]    In_Data = 8'h00;
  logic          In_Ready, Mem_WrEn, Core_Rst, Done, Error;
  logic [AW-1:0] Mem_Addr;
  logic [31:0]   Mem_WrData;
  int            n_tests = 0, n_fail = 0;
  logic [63:0]   sb[$];
  logic [63:0]   e;
  logic [31:0]   words[$];
  logic          tog = 1'b0, prev_wr = 1'b0;
  soc_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_Data    (In_Data),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Boot_Req   (Boot_Req),
    .Mem_WrEn   (Mem_WrEn),
    .Mem_Addr   (Mem_Addr),
    .Mem_WrData (Mem_WrData),
    .Core_Rst   (Core_Rst),
    .Done       (Done),
    .Error      (Error)
  );
  always #5 Clk = ~Clk;
  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (Mem_WrEn) begin
      check("wr_width", 64'(prev_wr), 64'd0);
      if (sb.size() == 0) check("spurious_wr", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("wr_addr", 64'(Mem_Addr), 64'(e[63:32]));
        check("wr_data", 64'(Mem_WrData), 64'(e[31:0]));
      end
    end
    prev_wr = Mem_WrEn;
  end
  task automatic send(input logic [7:0] b);
    int n = 0;
    In_Data  = b;
    In_Valid = 1'b1;
    while (!In_Ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!In_Ready) check("ready_timeout", 64'd0, 64'd1);
    @(negedge Clk);
    if (tog) begin
      In_Valid = 1'b0;
      @(negedge Clk);
    end
  endtask
  task automatic send_image(input logic [15:0] n, input logic bad);
    logic [7:0] ck = n[7:0] ^ n[15:8];
    send(n[7:0]);
    send(n[15:8]);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back({32'(BASE + i), words[i]});
      for (int b = 0; b < 4; b++) begin
        ck ^= words[i][8*b +: 8];
        send(words[i][8*b +: 8]);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send(bad ? ~ck : ck);
`else
    if (bad) ck = ~ck;
`endif
    In_Valid = 1'b0;
    @(negedge Clk);
  endtask
  task boot_req();
    Boot_Req = 1'b1;
    @(negedge Clk);
    Boot_Req = 1'b0;
    check("req_done", 64'(Done), 64'd0);
    check("req_error", 64'(Error), 64'd0);
    check("req_core_rst", 64'(Core_Rst), 64'd1);
    check("req_ready", 64'(In_Ready), 64'd1);
  endtask
  task expect_done(input string tag);
    check({tag, "_done"}, 64'(Done), 64'd1);
    check({tag, "_error"}, 64'(Error), 64'd0);
    check({tag, "_core_rst"}, 64'(Core_Rst), 64'd0);
    check({tag, "_ready"}, 64'(In_Ready), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask
  task expect_error(input string tag);
    check({tag, "_error"}, 64'(Error), 64'd1);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_core_rst"}, 64'(Core_Rst), 64'd1);
    check({tag, "_ready"}, 64'(In_Ready), 64'd0);
  endtask
  task expect_reset(input string tag);
    check({tag, "_ready"}, 64'(In_Ready), 64'd0);
    check({tag, "_core_rst"}, 64'(Core_Rst), 64'd1);
    check({tag, "_wren"}, 64'(Mem_WrEn), 64'd0);
    check({tag, "_addr"}, 64'(Mem_Addr), 64'(BASE));
    check({tag, "_wdata"}, 64'(Mem_WrData), 64'd0);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_error"}, 64'(Error), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge Clk);
    expect_reset("rst");
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_release_ready", 64'(In_Ready), 64'd1);
    words = '{32'h04030201, 32'hDDCCBBAA};
    send_image(16'd2, 1'b0);
    expect_done("n2");
    boot_req();
    tog = 1'b1;
    send_image(16'd2, 1'b0);
    tog = 1'b0;
    expect_done("n2_tog");
    boot_req();
    send_image(16'd0, 1'b0);
    expect_done("n0");
    boot_req();
    send(8'h01);
    send(8'h10);
    In_Valid = 1'b0;
    @(negedge Clk);
    expect_error("ovf");
    check("ovf_sb_empty", 64'(sb.size()), 64'd0);
    boot_req();
`ifdef BOOT_CHECKSUM_EN
    send_image(16'd2, 1'b1);
    expect_error("bad_ck");
    boot_req();
`endif
    send(8'h01);
    send(8'h00);
    send(8'h55);
    send(8'h66);
    In_Valid = 1'b0;
    Rst = 1'b0;
    @(negedge Clk);
    expect_reset("mid_rst");
    Rst = 1'b1;
    @(negedge Clk);
    words = '{32'h11223344};
    send_image(16'd1, 1'b0);
    expect_done("reload");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
